gshare_predictor: RTL and testbench

//  Gshare branch direction predictor: table of 2^IDX_BITS 2-bit saturating counters,

---
 rtl/gshare_if.sv | 39 +++
 rtl/gshare_predictor.sv | 123 ++++++++++++
 tb/tb_gshare_predictor.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gshare_if.sv
// Fetch/execute-side bus of the gshare predictor: fetch lookup plus resolved-branch training.
// The pipeline is the master; the predictor is the slave.
interface gshare_if #(
  parameter int IDX_BITS = 4
);
  logic [15:0]         fetch_pc;
  logic                predict_taken;
  logic [IDX_BITS-1:0] predict_idx;
  logic                ready;
  logic                resolve_valid;
  logic [IDX_BITS-1:0] resolve_idx;
  logic                resolve_taken;
  logic                resolve_predicted;
  logic [15:0]         mispredict_count;

  modport master (
    output fetch_pc,
    output resolve_valid,
    output resolve_idx,
    output resolve_taken,
    output resolve_predicted,
    input  predict_taken,
    input  predict_idx,
    input  ready,
    input  mispredict_count
  );

  modport slave (
    input  fetch_pc,
    input  resolve_valid,
    input  resolve_idx,
    input  resolve_taken,
    input  resolve_predicted,
    output predict_taken,
    output predict_idx,
    output ready,
    output mispredict_count
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: 2-bit counters indexed by PC XOR global history,
// trained non-speculatively from execute, with a saturating mispredict counter.
module gshare_predictor #(
  parameter int IDX_BITS  = 4,
  parameter int HIST_BITS = 4
) (
  input  logic    clk,
  input  logic    reset,
  gshare_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   init_ptr_q, init_ptr_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [1:0]            table_q [ENTRIES];

  logic [IDX_BITS-1:0]   ghr_ext;
  logic [IDX_BITS-1:0]   pred_idx;
  logic                  tbl_we;
  logic [IDX_BITS-1:0]   tbl_widx;
  logic [1:0]            tbl_wdata;
  logic                  unused_pc_bits;

  // PC bit 0 and the bits above the index never take part in the lookup.
  assign unused_pc_bits = ^{bus.fetch_pc[15:IDX_BITS+1], bus.fetch_pc[0]};

  // Lookup: history is zero-extended so short histories only perturb low index bits.
  always_comb begin
    ghr_ext                  = '0;
    ghr_ext[HIST_BITS-1:0]   = ghr_q;
    pred_idx                 = bus.fetch_pc[IDX_BITS:1] ^ ghr_ext;
  end

  assign bus.predict_idx      = pred_idx;
  assign bus.predict_taken    = ready_q & table_q[pred_idx][1];
  assign bus.ready            = ready_q;
  assign bus.mispredict_count = cnt_q;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    cnt_d      = cnt_q;
    tbl_we     = 1'b0;
    tbl_widx   = bus.resolve_idx;
    tbl_wdata  = table_q[bus.resolve_idx];

    case (state_q)
      S_INIT: begin
        tbl_we     = 1'b1;
        tbl_widx   = init_ptr_q;
        tbl_wdata  = 2'b01;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == {IDX_BITS{1'b1}}) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.resolve_valid) begin
          tbl_we    = 1'b1;
          tbl_wdata = bus.resolve_taken ? sat_inc2(table_q[bus.resolve_idx])
                                        : sat_dec2(table_q[bus.resolve_idx]);
          // Shift in the outcome; the cast keeps the newest HIST_BITS bits.
          ghr_d     = HIST_BITS'({ghr_q, bus.resolve_taken});
          if (bus.resolve_taken != bus.resolve_predicted) begin
            cnt_d = sat_inc16(cnt_q);
          end
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    ready_d = (state_d == S_RUN);
  end

  // Control state: reset restarts the initialisation sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
    end
  end

  // Counter table: no reset, contents are rebuilt by the INIT sweep.
  always_ff @(posedge clk) begin
    if (tbl_we && !reset) begin
      table_q[tbl_widx] <= tbl_wdata;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_gshare_predictor;

  localparam int K_READY = 0;
  localparam int K_TAKEN = 1;
  localparam int K_IDX   = 2;
  localparam int K_COUNT = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  logic [3:0]  ghr_m;
  logic [15:0] cnt_m;

  gshare_if #(.IDX_BITS(4)) bus ();

  gshare_predictor #(.IDX_BITS(4), .HIST_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are settled mid-cycle, compare everything queued this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_READY: act = {15'd0, bus.ready};
        K_TAKEN: act = {15'd0, bus.predict_taken};
        K_IDX:   act = {12'd0, bus.predict_idx};
        default: act = bus.mispredict_count;
      endcase
      checks = checks + 1;
      if (act !== e.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic chk(input string name, input int kind, input logic [15:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_resolve(input logic [3:0] idx, input logic t, input logic p);
    bus.resolve_valid     = 1'b1;
    bus.resolve_idx       = idx;
    bus.resolve_taken     = t;
    bus.resolve_predicted = p;
    step();
    bus.resolve_valid     = 1'b0;
    ghr_m = {ghr_m[2:0], t};
    if (t != p && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
  endtask

  // Aim the fetch PC so that the lookup lands on the wanted table entry.
  task automatic probe(input string name, input logic [3:0] target, input logic exp_t_bit);
    bus.fetch_pc = {11'd0, target ^ ghr_m, 1'b0};
    chk({name, "_idx"}, K_IDX, {12'd0, target});
    chk({name, "_taken"}, K_TAKEN, {15'd0, exp_t_bit});
    step();
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    ghr_m  = 4'd0;
    cnt_m  = 16'd0;
    reset                 = 1'b1;
    bus.fetch_pc          = 16'h0010;
    bus.resolve_valid     = 1'b0;
    bus.resolve_idx       = 4'd0;
    bus.resolve_taken     = 1'b0;
    bus.resolve_predicted = 1'b0;
    step();
    reset = 1'b0;

    // Reset state and 16-cycle INIT with ignored resolves.
    chk("rst_count", K_COUNT, 16'h0000);
    chk("rst_idx", K_IDX, 16'h0008);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("init_ready_%0d", i), K_READY, 16'h0000);
      chk($sformatf("init_taken_%0d", i), K_TAKEN, 16'h0000);
      bus.resolve_valid     = 1'b1;
      bus.resolve_idx       = 4'd8;
      bus.resolve_taken     = 1'b1;
      bus.resolve_predicted = 1'b0;
      step();
    end
    bus.resolve_valid = 1'b0;
    chk("run_ready", K_READY, 16'h0001);
    chk("run_count", K_COUNT, 16'h0000);
    chk("run_idx_ghr0", K_IDX, 16'h0008);
    chk("run_taken", K_TAKEN, 16'h0000);
    step();

    // Counter training upwards on idx 3.
    probe("t2_start", 4'd3, 1'b0);
    do_resolve(4'd3, 1'b1, 1'b0);
    probe("t2_wt", 4'd3, 1'b1);
    do_resolve(4'd3, 1'b1, 1'b1);
    do_resolve(4'd3, 1'b1, 1'b1);
    probe("t2_st", 4'd3, 1'b1);
    do_resolve(4'd3, 1'b0, 1'b1);
    probe("t2_back_wt", 4'd3, 1'b1);

    // Counter training downwards on idx 5, probing after each step.
    for (int i = 0; i < 5; i++) begin
      do_resolve(4'd5, 1'b0, 1'b0);
      probe($sformatf("t3_nt%0d", i), 4'd5, 1'b0);
    end
    do_resolve(4'd5, 1'b1, 1'b0);
    probe("t3_wnt", 4'd5, 1'b0);
    chk("t3_count", K_COUNT, 16'd3);
    step();

    // History T,N,T,T -> 1011, so PC 0 indexes entry B.
    do_resolve(4'd9, 1'b1, 1'b1);
    do_resolve(4'd9, 1'b0, 1'b0);
    do_resolve(4'd9, 1'b1, 1'b1);
    do_resolve(4'd9, 1'b1, 1'b1);
    bus.fetch_pc = 16'h0000;
    chk("t4_idx", K_IDX, 16'h000B);
    chk("t4_taken", K_TAKEN, 16'h0000);
    step();

    // Same-cycle read and write of entry C: old value now, new value next cycle.
    bus.fetch_pc = 16'h000E;
    chk("t5_same_idx", K_IDX, 16'h000C);
    chk("t5_old", K_TAKEN, 16'h0000);
    do_resolve(4'hC, 1'b1, 1'b0);
    probe("t5_new", 4'hC, 1'b1);
    chk("t5_count", K_COUNT, 16'd4);
    step();

    // Drive the mispredict count to FFFE, then across saturation.
    n = 16'hFFFE - int'(cnt_m);
    bus.resolve_valid     = 1'b1;
    bus.resolve_idx       = 4'd0;
    bus.resolve_taken     = 1'b1;
    bus.resolve_predicted = 1'b0;
    for (int i = 0; i < n; i++) step();
    bus.resolve_valid = 1'b0;
    ghr_m = 4'hF;
    cnt_m = 16'hFFFE;
    chk("t6_fffe", K_COUNT, 16'hFFFE);
    step();
    do_resolve(4'd0, 1'b1, 1'b0);
    chk("t6_ffff", K_COUNT, 16'hFFFF);
    do_resolve(4'd0, 1'b0, 1'b1);
    chk("t6_hold", K_COUNT, 16'hFFFF);
    do_resolve(4'd0, 1'b1, 1'b0);
    chk("t6_hold2", K_COUNT, 16'hFFFF);
    step();

    // Reset in the middle of RUN restarts INIT and discards the table.
    reset = 1'b1;
    step();
    reset = 1'b0;
    ghr_m = 4'd0;
    cnt_m = 16'd0;
    bus.fetch_pc = 16'h0006;
    chk("rr_idx", K_IDX, 16'h0003);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rr_ready_%0d", i), K_READY, 16'h0000);
      chk($sformatf("rr_count_%0d", i), K_COUNT, 16'h0000);
      step();
    end
    chk("rr_ready_run", K_READY, 16'h0001);
    step();
    probe("rr_idx3", 4'd3, 1'b0);
    probe("rr_idx0", 4'd0, 1'b0);

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
